rr_lut_ff_arbiter: RTL and testbench
====================================

Name: rr_lut_ff_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one registered LUT-OR/flip-flop stage among NREQ requesters.
- Each requester presents an operand pair. The granted requester's pair is ORed through the shared LUT and captured in the shared result flop.
- Output side is a valid/ready handshake with backpressure.
- Intended as the next interchange feature test: LUT plus FF plus control logic, placed and routed as one top-level design.

Parameters:
- NREQ, 3, number of requesters (>=1).
- W, 2, operand and result width in bits.
- IDW, ($clog2(NREQ) < 1 ? 1 : $clog2(NREQ)), derived width of res_id and ptr; not overridden.

Ports:
- C  input  1  clock; all state updates on rising edge.
- R  input  1  reset, synchronous, active-high.
- req  input  NREQ  request per requester; bit k = requester k.
- a  input  NREQ*W  operand A; requester k uses a[k*W +: W].
- b  input  NREQ*W  operand B; requester k uses b[k*W +: W].
- gnt  output  NREQ  one-hot grant, combinational, asserted in the acceptance cycle.
- res  output  W  registered result, a_k | b_k of the last accepted requester.
- res_id  output  IDW  index of the requester that produced res.
- res_vld  output  1  res/res_id valid.
- res_rdy  input  1  consumer accepts res when res_vld && res_rdy.

Behaviour:
- Reset (R=1 at edge): res=0, res_id=0, res_vld=0, ptr=0. gnt is forced to 0 whenever R=1.
- can_issue = !res_vld || res_rdy. This allows one result in flight and full throughput on back-to-back accepts.
- Arbitration (combinational): scan indices ptr, ptr+1, ..., wrapping NREQ-1 -> 0. The first k with req[k]=1 wins.
  - gnt[k]=1 only if can_issue && !R; otherwise gnt=0.
  - At most one gnt bit is set.
- On an edge with gnt[k]=1: res <= a_k | b_k; res_id <= k; res_vld <= 1; ptr <= (k==NREQ-1) ? 0 : k+1.
- On an edge with no grant, res_vld && res_rdy: res_vld <= 0. res and res_id hold their last values; ptr is unchanged.
- Stall (res_vld && !res_rdy): gnt=0; res, res_id, res_vld and ptr hold.
- Simultaneous consume and grant: a new result replaces the old one on the same edge, and res_vld stays 1.
- Latency: result is visible exactly 1 cycle after gnt. Throughput is 1 grant per cycle when res_rdy=1.
- Requester protocol:
  - Hold req and operands stable until gnt is seen.
  - Deasserting req before gnt is legal; the request is withdrawn with no side effect.
  - After a grant, req may stay high to request again.
- Fairness: with all requesters continuously asserted and res_rdy=1, each gets exactly one grant every NREQ cycles.
- NREQ=1: ptr is constant 0 and gnt = req[0] && can_issue.
- Reset mid-operation: a pending result is discarded (res_vld=0) and ptr returns to 0; no grant is issued in the reset cycle.
- FSM view (derived from res_vld): EMPTY (res_vld=0) and FULL (res_vld=1).
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY on consume without grant.
  - FULL -> FULL on stall, or on consume with grant.

Optional Feature:
- Macro: RR_LUT_FF_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. ptr is held at 0 and never updated; all other behaviour is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset: R=1 for 2 cycles with req=3'b111 -> gnt=0 throughout; afterwards res=0, res_id=0, res_vld=0.
- Single request: req=3'b001, a0=2'b01, b0=2'b10, res_rdy=1 -> gnt=3'b001 that cycle; next cycle res=2'b11, res_id=0, res_vld=1.
- Round-robin: req=3'b111 held, res_rdy=1 -> gnt 001, 010, 100, 001 on consecutive cycles; res_id 0, 1, 2, 0, each one cycle later.
- Backpressure: res_vld=1, res_rdy=0, req=3'b010 for 3 cycles -> gnt=0 and res/res_id stable. Raise res_rdy -> gnt=3'b010 same cycle; next cycle res=a1|b1, res_id=1, res_vld=1.
- Reset mid-operation: res_vld=1 with ptr=2, assert R for 1 cycle -> res_vld=0. Then req=3'b111 -> first gnt=3'b001.
- With RR_LUT_FF_ARBITER_FIXED_PRIO_EN defined: req=3'b111 held, res_rdy=1 -> gnt=3'b001 every cycle; drop req[0] -> gnt=3'b010.

Source files
------------

// File: rtl/rr_lut_ff_arbiter.sv
// Round-robin arbiter sharing one registered OR stage among NREQ requesters.
// Define RR_LUT_FF_ARBITER_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module rr_lut_ff_arbiter #(
   parameter int NREQ = 3,
   parameter int W    = 2,
   parameter int IDW  = ($clog2(NREQ) < 1) ? 1 : $clog2(NREQ)
) (
   input  logic              C,
   input  logic              R,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] a,
   input  logic [NREQ*W-1:0] b,
   output logic [NREQ-1:0]   gnt,
   output logic [W-1:0]      res,
   output logic [IDW-1:0]    res_id,
   output logic              res_vld,
   input  logic              res_rdy
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t         state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] sel;
   logic           found;
   logic           can_issue;
   logic [W-1:0]   lut;
   int             idx;

   assign res_vld   = (state == FULL);
   assign can_issue = (state == EMPTY) || res_rdy;

   // Scan from ptr with wrap; first active request wins.
   always_comb begin
      gnt   = '0;
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      if (can_issue && !R) begin
         for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
               found    = 1'b1;
               gnt[idx] = 1'b1;
               sel      = IDW'(idx);
            end
         end
      end
   end

   assign lut = a[int'(sel)*W +: W] | b[int'(sel)*W +: W];

   always_ff @(posedge C) begin
      if (R) begin
         state  <= EMPTY;
         res    <= '0;
         res_id <= '0;
      end else if (found) begin
         state  <= FULL;
         res    <= lut;
         res_id <= sel;
      end else if (state == FULL && res_rdy) begin
         state  <= EMPTY;
      end
   end

`ifdef RR_LUT_FF_ARBITER_FIXED_PRIO_EN
   assign ptr = '0;
`else
   always_ff @(posedge C) begin
      if (R) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= (sel == IDW'(NREQ-1)) ? '0 : sel + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_rr_lut_ff_arbiter.sv
// Scoreboard bench for rr_lut_ff_arbiter: reference model predicts grants,
// queues expected results and compares them one cycle later.
module tb_rr_lut_ff_arbiter;

   localparam int NREQ = 3;
   localparam int W    = 2;
   localparam int IDW  = 2;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [W-1:0]   res;
   } exp_t;

   logic              C = 1'b0;
   logic              R = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*W-1:0] a = '0;
   logic [NREQ*W-1:0] b = '0;
   logic [NREQ-1:0]   gnt;
   logic [W-1:0]      res;
   logic [IDW-1:0]    res_id;
   logic              res_vld;
   logic              res_rdy = 1'b1;

   int checks = 0;
   int errors = 0;

   exp_t       sb[$];
   int         m_ptr = 0;
   logic       m_vld = 1'b0;
   logic [W-1:0]   m_res = '0;
   logic [IDW-1:0] m_id  = '0;

   rr_lut_ff_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .C(C), .R(R), .req(req), .a(a), .b(b), .gnt(gnt),
      .res(res), .res_id(res_id), .res_vld(res_vld), .res_rdy(res_rdy)
   );

   always #5 C = ~C;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp,
                  $time);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] r, input int p);
      for (int i = 0; i < NREQ; i++) begin
         if (r[(p + i) % NREQ]) return (p + i) % NREQ;
      end
      return -1;
   endfunction

   task automatic step();
      int k;
      logic [NREQ-1:0] eg;
      exp_t e;
      #1;
      k = -1;
      if (!R && (!m_vld || res_rdy)) k = pick(req, m_ptr);
      eg = '0;
      if (k >= 0) eg[k] = 1'b1;
      chk("gnt", 32'(gnt), 32'(eg));
      if (k >= 0) begin
         e.id  = k[IDW-1:0];
         e.res = a[k*W +: W] | b[k*W +: W];
         sb.push_back(e);
      end
      @(posedge C);
      #1;
      if (R) begin
         m_vld = 1'b0;
         m_ptr = 0;
         m_res = '0;
         m_id  = '0;
         sb.delete();
      end else if (k >= 0) begin
         chk("sb_size", 32'(sb.size()), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            m_res = e.res;
            m_id  = e.id;
         end
         m_vld = 1'b1;
`ifndef RR_LUT_FF_ARBITER_FIXED_PRIO_EN
         m_ptr = (k == NREQ-1) ? 0 : k + 1;
`endif
      end else if (m_vld && res_rdy) begin
         m_vld = 1'b0;
      end
      chk("res_vld", 32'(res_vld), 32'(m_vld));
      chk("res", 32'(res), 32'(m_res));
      chk("res_id", 32'(res_id), 32'(m_id));
   endtask

   initial begin
      // Reset held two cycles with all requests active
      R = 1'b1; req = 3'b111; a = 6'h2d; b = 6'h13; res_rdy = 1'b1;
      step(); step();
      chk("rst_res", 32'(res), 32'd0);
      chk("rst_vld", 32'(res_vld), 32'd0);
      R = 1'b0;

      // Single request: 01 | 10 = 11 from requester 0
      req = 3'b001; a = 6'b000001; b = 6'b000010;
      step();
      chk("single_res", 32'(res), 32'd3);
      chk("single_id", 32'(res_id), 32'd0);
      req = 3'b000;
      step();

      // Restart pointer, then rotate with all requests held
      R = 1'b1; step(); R = 1'b0;
      req = 3'b111;
      for (int i = 0; i < 4; i++) begin
         a = 6'($urandom); b = 6'($urandom);
         step();
      end
      chk("rr_id_last", 32'(res_id), 32'd0);

      // Backpressure then release
      res_rdy = 1'b0; req = 3'b010; a = 6'b001000; b = 6'b000100;
      for (int i = 0; i < 3; i++) step();
      res_rdy = 1'b1;
      step();
      chk("bp_res", 32'(res), 32'd3);
      chk("bp_id", 32'(res_id), 32'd1);

      // Reset mid-operation with a pending result and ptr=2
      R = 1'b1; step(); R = 1'b0;
      req = 3'b111;
      step();
      chk("post_rst_id", 32'(res_id), 32'd0);

      // Priority check with requester 0 dropped
      step(); step();
      req = 3'b110;
      step(); step();

      // Randomised traffic with backpressure and occasional reset
      for (int i = 0; i < 400; i++) begin
         req     = 3'($urandom);
         a       = 6'($urandom);
         b       = 6'($urandom);
         res_rdy = ($urandom_range(0, 3) != 0);
         R       = ($urandom_range(0, 39) == 0);
         step();
      end
      R = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
